// File: rtl/csr_trap_ctrl_pkg.sv
// csr_trap_ctrl_pkg: shared CSR addresses, mstatus field positions, trap causes and FSM states
package csr_trap_ctrl_pkg;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_MEPC = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam int MSTATUS_MIE = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MSTATUS_MPP_LO = 11;
  localparam logic [31:0] ECALL_CAUSE_C = 32'h0000000B;
  localparam logic [31:0] IRQ_CAUSE_C = 32'h8000000B;
  typedef enum logic [2:0] {S_IDLE, S_T_EPC, S_T_CAUSE, S_T_STATUS, S_R_STATUS} state_e;
endpackage

// File: rtl/csr_mstatus_upd.sv
// csr_mstatus_upd: mstatus bit transform for trap entry (is_mret_i=0) or mret (is_mret_i=1)
module csr_mstatus_upd
  import csr_trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mstatus_i,
  input  logic            is_mret_i,
  output logic [XLEN-1:0] mstatus_o
);
  always_comb begin
    mstatus_o = mstatus_i;
    mstatus_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_o[MSTATUS_MIE] = is_mret_i ? mstatus_i[MSTATUS_MPIE] : 1'b0;
    mstatus_o[MSTATUS_MPIE] = is_mret_i ? 1'b1 : mstatus_i[MSTATUS_MIE];
  end
endmodule

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: arbitrates the CSR write port between CSR instructions and trap entry/return sequences
module csr_trap_ctrl
  import csr_trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CSR_AW = 12,
  parameter logic [XLEN-1:0] ECALL_CAUSE = ECALL_CAUSE_C,
  parameter logic [XLEN-1:0] IRQ_CAUSE = IRQ_CAUSE_C
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              ins_csr_we_i,
  input  logic [CSR_AW-1:0] ins_csr_addr_i,
  input  logic [XLEN-1:0]   ins_csr_wdata_i,
  input  logic              ecall_i,
  input  logic              mret_i,
  input  logic [XLEN-1:0]   commit_pc_i,
  input  logic              irq_i,
  input  logic [XLEN-1:0]   mstatus_i,
  input  logic [XLEN-1:0]   mtvec_i,
  input  logic [XLEN-1:0]   mepc_i,
  output logic              csr_we_o,
  output logic [CSR_AW-1:0] csr_waddr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              stall_o,
  output logic              flush_o,
  output logic              redirect_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              busy_o
);
  state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, cause_q, cause_d, ms_upd, wdata, rpc;
  logic [CSR_AW-1:0] waddr;
  logic init_q, en, we, stall, flush, take_irq;
  assign en = init_q & ~rst;
  assign take_irq = irq_i & mstatus_i[MSTATUS_MIE];
  csr_mstatus_upd #(.XLEN(XLEN)) u_upd (
    .mstatus_i(mstatus_i),
    .is_mret_i(state_q == S_R_STATUS),
    .mstatus_o(ms_upd)
  );
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q <= '0;
      cause_q <= '0;
      init_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      cause_q <= cause_d;
      init_q <= 1'b1;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    cause_d = cause_q;
    we = 1'b0;
    waddr = '0;
    wdata = '0;
    stall = state_q != S_IDLE;
    flush = 1'b0;
    rpc = '0;
    case (state_q)
      S_IDLE: begin
        we = ins_csr_we_i;
        waddr = ins_csr_addr_i;
        wdata = ins_csr_wdata_i;
        if (en && (take_irq || ecall_i)) begin
          state_d = S_T_EPC;
          pc_d = commit_pc_i;
          cause_d = take_irq ? IRQ_CAUSE : ECALL_CAUSE;
          stall = 1'b1;
        end else if (en && mret_i) begin
          state_d = S_R_STATUS;
          stall = 1'b1;
        end
      end
      S_T_EPC: begin
        we = 1'b1;
        waddr = CSR_MEPC;
        wdata = pc_q;
        state_d = S_T_CAUSE;
      end
      S_T_CAUSE: begin
        we = 1'b1;
        waddr = CSR_MCAUSE;
        wdata = cause_q;
        state_d = S_T_STATUS;
      end
      S_T_STATUS: begin
        we = 1'b1;
        waddr = CSR_MSTATUS;
        wdata = ms_upd;
        flush = 1'b1;
        rpc = mtvec_i & ~XLEN'(3);
        state_d = S_IDLE;
      end
      S_R_STATUS: begin
        we = 1'b1;
        waddr = CSR_MSTATUS;
        wdata = ms_upd;
        flush = 1'b1;
        rpc = mepc_i;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign csr_we_o = en & we;
  assign csr_waddr_o = en ? waddr : '0;
  assign csr_wdata_o = en ? wdata : '0;
  assign stall_o = en & stall;
  assign flush_o = en & flush;
  assign redirect_o = en & flush;
  assign redirect_pc_o = en ? rpc : '0;
  assign busy_o = en & (state_q != S_IDLE);
endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl: directed vector table plus randomized run against a sequence-queue reference model
module tb_csr_trap_ctrl;
  typedef struct packed {
    logic        rst;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wd;
    logic        ecall;
    logic        mret;
    logic        irq;
    logic [31:0] cpc;
    logic [31:0] ms;
    logic [31:0] mtvec;
    logic [31:0] mepc;
  } in_t;
  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wd;
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
    logic        busy;
  } out_t;
  typedef struct {
    string n;
    in_t   i;
    out_t  o;
  } vec_t;
  typedef enum {K_EPC, K_CAUSE, K_TST, K_RST} kind_e;
  typedef struct {
    kind_e       k;
    logic [31:0] pc;
    logic [31:0] cause;
  } op_t;

  logic clk_i = 1'b0;
  logic rst = 1'b1;
  logic ins_csr_we_i = 1'b0;
  logic [11:0] ins_csr_addr_i = '0;
  logic [31:0] ins_csr_wdata_i = '0;
  logic ecall_i = 1'b0;
  logic mret_i = 1'b0;
  logic [31:0] commit_pc_i = '0;
  logic irq_i = 1'b0;
  logic [31:0] mstatus_i = '0;
  logic [31:0] mtvec_i = '0;
  logic [31:0] mepc_i = '0;
  logic csr_we_o, stall_o, flush_o, redirect_o, busy_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o, redirect_pc_o;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];
  op_t ops[$];
  bit m_init = 0;
  logic [11:0] addrs[5] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h340};

  csr_trap_ctrl dut (
    .clk_i(clk_i), .rst(rst),
    .ins_csr_we_i(ins_csr_we_i), .ins_csr_addr_i(ins_csr_addr_i), .ins_csr_wdata_i(ins_csr_wdata_i),
    .ecall_i(ecall_i), .mret_i(mret_i), .commit_pc_i(commit_pc_i), .irq_i(irq_i),
    .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .stall_o(stall_o), .flush_o(flush_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic in_t mi(bit r, bit w, logic [11:0] a, logic [31:0] d, bit e, bit m, bit q,
                             logic [31:0] pc, logic [31:0] ms, logic [31:0] tv, logic [31:0] ep);
    return {r, w, a, d, e, m, q, pc, ms, tv, ep};
  endfunction

  function automatic out_t mo(bit w, logic [11:0] a, logic [31:0] d, bit s, bit f, bit rd,
                              logic [31:0] rp, bit b);
    return {w, a, d, s, f, rd, rp, b};
  endfunction

  // Reference: a trap is a queue of pending writes, one consumed per cycle.
  function automatic out_t model(in_t x);
    out_t o = '0;
    op_t op;
    if (x.rst) begin
      ops.delete();
      m_init = 0;
      return o;
    end
    if (!m_init) begin
      m_init = 1;
      return o;
    end
    if (ops.size() > 0) begin
      op = ops.pop_front();
      o.we = 1;
      o.stall = 1;
      o.busy = 1;
      case (op.k)
        K_EPC: begin o.addr = 12'h341; o.wd = op.pc; end
        K_CAUSE: begin o.addr = 12'h342; o.wd = op.cause; end
        K_TST: begin
          o.addr = 12'h300;
          o.wd = (x.ms & ~32'h1888) | 32'h1800 | (x.ms[3] ? 32'h80 : 32'h0);
          o.flush = 1; o.redir = 1;
          o.rpc = x.mtvec - (x.mtvec % 4);
        end
        default: begin
          o.addr = 12'h300;
          o.wd = (x.ms & ~32'h1888) | 32'h1880 | (x.ms[7] ? 32'h8 : 32'h0);
          o.flush = 1; o.redir = 1;
          o.rpc = x.mepc;
        end
      endcase
      return o;
    end
    o.we = x.we;
    o.addr = x.addr;
    o.wd = x.wd;
    if ((x.irq && x.ms[3]) || x.ecall) begin
      o.stall = 1;
      ops.push_back('{K_EPC, x.cpc, 32'h0});
      ops.push_back('{K_CAUSE, 32'h0, (x.irq && x.ms[3]) ? 32'h8000000B : 32'h0000000B});
      ops.push_back('{K_TST, 32'h0, 32'h0});
    end else if (x.mret) begin
      o.stall = 1;
      ops.push_back('{K_RST, 32'h0, 32'h0});
    end
    return o;
  endfunction

  task automatic apply(in_t x);
    rst = x.rst;
    ins_csr_we_i = x.we;
    ins_csr_addr_i = x.addr;
    ins_csr_wdata_i = x.wd;
    ecall_i = x.ecall;
    mret_i = x.mret;
    irq_i = x.irq;
    commit_pc_i = x.cpc;
    mstatus_i = x.ms;
    mtvec_i = x.mtvec;
    mepc_i = x.mepc;
    #1;
  endtask

  task automatic check(string n, out_t exp);
    out_t act;
    act = {csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, flush_o, redirect_o, redirect_pc_o, busy_o};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act we=%b a=%h d=%h st=%b fl=%b rd=%b pc=%h bz=%b exp we=%b a=%h d=%h st=%b fl=%b rd=%b pc=%h bz=%b",
               n, act.we, act.addr, act.wd, act.stall, act.flush, act.redir, act.rpc, act.busy,
               exp.we, exp.addr, exp.wd, exp.stall, exp.flush, exp.redir, exp.rpc, exp.busy);
    end
  endtask

  initial begin
    in_t x;
    out_t e;
    tbl.push_back('{"rst", mi(1, 1, 12'h305, 32'h55, 1, 0, 0, 0, 32'h1808, 32'h80000101, 0), mo(0, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"post_rst", mi(0, 1, 12'h305, 32'h55, 1, 0, 0, 0, 32'h1808, 32'h80000101, 0), mo(0, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"idle_pass", mi(0, 1, 12'h305, 32'h80000101, 0, 0, 0, 0, 32'h1808, 32'h80000101, 0), mo(1, 12'h305, 32'h80000101, 0, 0, 0, 0, 0)});
    tbl.push_back('{"ecall_acc", mi(0, 0, 0, 0, 1, 0, 0, 32'h80000010, 32'h1808, 32'h80000101, 0), mo(0, 0, 0, 1, 0, 0, 0, 0)});
    tbl.push_back('{"ecall_epc", mi(0, 0, 0, 0, 0, 0, 0, 0, 32'h1808, 32'h80000101, 0), mo(1, 12'h341, 32'h80000010, 1, 0, 0, 0, 1)});
    tbl.push_back('{"ecall_cause", mi(0, 0, 0, 0, 0, 0, 0, 0, 32'h1808, 32'h80000101, 0), mo(1, 12'h342, 32'hB, 1, 0, 0, 0, 1)});
    tbl.push_back('{"ecall_status", mi(0, 0, 0, 0, 0, 0, 0, 0, 32'h1808, 32'h80000101, 0), mo(1, 12'h300, 32'h1880, 1, 1, 1, 32'h80000100, 1)});
    tbl.push_back('{"ecall_idle", mi(0, 0, 0, 0, 0, 0, 0, 0, 32'h1880, 32'h80000101, 0), mo(0, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"mret_acc", mi(0, 0, 0, 0, 0, 1, 0, 0, 32'h1880, 32'h80000101, 32'h80000014), mo(0, 0, 0, 1, 0, 0, 0, 0)});
    tbl.push_back('{"mret_status", mi(0, 0, 0, 0, 0, 0, 0, 0, 32'h1880, 32'h80000101, 32'h80000014), mo(1, 12'h300, 32'h1888, 1, 1, 1, 32'h80000014, 1)});
    tbl.push_back('{"mret_idle", mi(0, 0, 0, 0, 0, 0, 0, 0, 32'h1888, 32'h80000101, 32'h80000014), mo(0, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"irq_masked1", mi(0, 1, 12'h342, 32'h1234, 0, 0, 1, 0, 32'h1800, 32'h80000101, 0), mo(1, 12'h342, 32'h1234, 0, 0, 0, 0, 0)});
    tbl.push_back('{"irq_masked2", mi(0, 1, 12'h300, 32'h1808, 0, 0, 1, 0, 32'h1800, 32'h80000101, 0), mo(1, 12'h300, 32'h1808, 0, 0, 0, 0, 0)});
    tbl.push_back('{"irq_acc", mi(0, 0, 0, 0, 0, 0, 1, 32'h80000040, 32'h1808, 32'h80000101, 0), mo(0, 0, 0, 1, 0, 0, 0, 0)});
    tbl.push_back('{"irq_epc", mi(0, 0, 0, 0, 0, 0, 1, 0, 32'h1808, 32'h80000101, 0), mo(1, 12'h341, 32'h80000040, 1, 0, 0, 0, 1)});
    tbl.push_back('{"irq_cause", mi(0, 0, 0, 0, 0, 0, 1, 0, 32'h1808, 32'h80000101, 0), mo(1, 12'h342, 32'h8000000B, 1, 0, 0, 0, 1)});
    tbl.push_back('{"irq_status", mi(0, 0, 0, 0, 0, 0, 0, 0, 32'h1808, 32'h80000101, 0), mo(1, 12'h300, 32'h1880, 1, 1, 1, 32'h80000100, 1)});
    tbl.push_back('{"irq_idle", mi(0, 0, 0, 0, 0, 0, 0, 0, 32'h1880, 32'h80000101, 0), mo(0, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"mtvec_acc", mi(0, 1, 12'h305, 32'h80000200, 1, 0, 0, 32'h80000020, 32'h1808, 32'h80000101, 0), mo(1, 12'h305, 32'h80000200, 1, 0, 0, 0, 0)});
    tbl.push_back('{"mtvec_epc", mi(0, 0, 0, 0, 0, 0, 0, 0, 32'h1808, 32'h80000200, 0), mo(1, 12'h341, 32'h80000020, 1, 0, 0, 0, 1)});
    tbl.push_back('{"held_cause", mi(0, 1, 12'h305, 32'hDEAD, 0, 0, 0, 0, 32'h1808, 32'h80000200, 0), mo(1, 12'h342, 32'hB, 1, 0, 0, 0, 1)});
    tbl.push_back('{"held_status", mi(0, 1, 12'h305, 32'hDEAD, 0, 0, 0, 0, 32'h1808, 32'h80000200, 0), mo(1, 12'h300, 32'h1880, 1, 1, 1, 32'h80000200, 1)});
    tbl.push_back('{"held_idle", mi(0, 1, 12'h305, 32'hDEAD, 0, 0, 0, 0, 32'h1880, 32'h80000200, 0), mo(1, 12'h305, 32'hDEAD, 0, 0, 0, 0, 0)});
    tbl.push_back('{"rstseq_acc", mi(0, 0, 0, 0, 1, 0, 0, 32'h80000030, 32'h1808, 32'h80000200, 0), mo(0, 0, 0, 1, 0, 0, 0, 0)});
    tbl.push_back('{"rstseq_epc", mi(0, 0, 0, 0, 0, 0, 0, 0, 32'h1808, 32'h80000200, 0), mo(1, 12'h341, 32'h80000030, 1, 0, 0, 0, 1)});
    tbl.push_back('{"rstseq_rst", mi(1, 0, 0, 0, 0, 0, 0, 0, 32'h1808, 32'h80000200, 0), mo(0, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"rstseq_post", mi(0, 0, 0, 0, 0, 0, 0, 0, 32'h1808, 32'h80000200, 0), mo(0, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{"rstseq_idle", mi(0, 0, 0, 0, 0, 0, 0, 0, 32'h1808, 32'h80000200, 0), mo(0, 0, 0, 0, 0, 0, 0, 0)});
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk_i);
      apply(tbl[i].i);
      check(tbl[i].n, tbl[i].o);
    end
    for (int c = 0; c < 3000; c++) begin
      x.rst = (c == 0) || ($urandom_range(99) == 0);
      x.we = 1'($urandom_range(1));
      x.addr = addrs[$urandom_range(4)];
      x.wd = $urandom();
      x.ecall = $urandom_range(7) == 0;
      x.mret = $urandom_range(9) == 0;
      x.irq = $urandom_range(3) == 0;
      x.cpc = $urandom();
      x.ms = $urandom();
      x.mtvec = $urandom();
      x.mepc = $urandom();
      e = model(x);
      @(negedge clk_i);
      apply(x);
      check("random", e);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
